multiword_add_seq: RTL and testbench
====================================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter N, default 8: width of the ripple-carry adder slice, in bits per word; SHALL be >= 1.
REQ-002 Parameter WORDS, default 4: number of words per operand; SHALL be >= 1; total width W = N*WORDS.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands and mode are presented.
REQ-006 in_ready  output  1  block accepts an operation (high only in IDLE).
REQ-007 a, b  input  W each  unsigned/two's-complement operands.
REQ-008 sub  input  1  0: a+b; 1: a-b.
REQ-009 out_valid  output  1  result fields valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 sum  output  W  result.
REQ-012 c_out  output  1  carry out of the top word (for sub, 1 = no borrow).
REQ-013 overflow  output  1  signed overflow.
REQ-014 zero  output  1  sum == 0.
REQ-015 busy  output  1  state != IDLE.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1; on in_valid at an edge, capture a, b_eff = sub ? ~b : b, carry = sub, word index = 0; go to RUN.
REQ-018 RUN: each edge adds word[idx] of a and b_eff with the carry register through one N-bit slice; write the slice sum into sum[idx*N +: N]; register the slice carry-out; idx increments.
REQ-019 RUN: on the edge processing idx = WORDS-1, go to DONE and latch c_out, overflow and zero; WORDS=1 SHALL take exactly one RUN cycle.
REQ-020 Latency: out_valid SHALL rise exactly WORDS edges after the accepting edge, independent of operand values.
REQ-021 overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
REQ-022 DONE: out_valid=1; sum, c_out, overflow and zero SHALL be held stable until the edge where out_ready=1, then go to IDLE.
REQ-023 in_ready=0 in RUN and DONE; in_valid is ignored there, including while out_valid and out_ready are both high (no same-cycle re-accept).
REQ-024 Captured operands SHALL NOT change if a, b or sub change after acceptance.
REQ-025 Index counter width is max(1, $clog2(WORDS)); it SHALL NOT wrap during one operation.

Reset
REQ-026 rst at any edge, including mid-RUN or in DONE, SHALL force IDLE, in_ready=1, out_valid=0, busy=0, sum=0, c_out=0, overflow=0, zero=0, and clear the carry and index registers; a partial result SHALL be discarded.
REQ-027 rst SHALL take priority over any handshake in the same cycle.

Structure
REQ-028 A shared package adder_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE).
REQ-029 Exactly one sub-module: a single adder_n instance, with N set to the word width, as the per-cycle slice; no other arithmetic operator SHALL produce sum.

Verification (N=8, WORDS=4)
REQ-030 0x000000FF + 0x00000001, sub=0 -> sum=0x00000100, c_out=0, overflow=0, zero=0; out_valid 4 edges after accept.
REQ-031 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, c_out=1, zero=1, overflow=0 (carry ripples through all words).
REQ-032 0x00000005 - 0x00000007, sub=1 -> sum=0xFFFFFFFE, c_out=0, overflow=0; then 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, overflow=1.
REQ-033 Hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> result held, in_ready=0, nothing accepted; out_ready=1 -> IDLE next edge.
REQ-034 Assert rst on the 2nd RUN edge -> next cycle in_ready=1, out_valid=0, sum=0; a new operation then completes with a correct result.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the word-serial adder: FSM state encoding.
package adder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_n.sv
// N-bit ripple-carry adder slice; the only arithmetic that produces the result.
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end
endmodule

// File: rtl/multiword_add_seq.sv
// Word-serial add/subtract: one N-bit word per cycle through a shared slice.
// Handshake: input accepted on an edge where in_valid && in_ready; the result
// is consumed on an edge where out_valid && out_ready.
module multiword_add_seq
  import adder_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic [1:0]       fsm_state
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t        state, state_next;
  logic [W-1:0]  a_reg, b_reg, sum_reg, sum_next;
  logic          carry, c_out_reg, ovf_reg, zero_reg;
  logic [IW-1:0] idx;
  logic [N-1:0]  slice_s;
  logic          slice_c;
  logic          last_word;

  adder_n #(.N(N)) u_slice (
    .a    (a_reg[idx*N +: N]),
    .b    (b_reg[idx*N +: N]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_c)
  );

  assign last_word = (idx == LAST_IDX);

  // Sum with the current slice merged in, so zero/overflow see the final word.
  always_comb begin
    sum_next = sum_reg;
    sum_next[idx*N +: N] = slice_s;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_word) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= a;
          b_reg <= sub ? ~b : b;
          carry <= sub;
          idx   <= '0;
        end
        RUN: begin
          sum_reg <= sum_next;
          carry   <= slice_c;
          if (last_word) begin
            c_out_reg <= slice_c;
            ovf_reg   <= (a_reg[W-1] == b_reg[W-1]) && (sum_next[W-1] != a_reg[W-1]);
            zero_reg  <= (sum_next == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = sum_reg;
  assign c_out    = c_out_reg;
  assign overflow = ovf_reg;
  assign zero     = zero_reg;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed table-driven bench for multiword_add_seq (N=8, WORDS=4).
module tb_multiword_add_seq;
  localparam int N = 8;
  localparam int WORDS = 4;
  localparam int W = N * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         c_out, overflow, zero, busy;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         c;
    logic         ovf;
    logic         z;
  } vec_t;

  vec_t vecs[8];

  multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow), .zero(zero),
    .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an operation for one edge, then scramble the inputs.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    @(negedge clk);
    check("in_ready_before", W'(in_ready), W'(1));
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = ~ts;
  endtask

  task automatic wait_result(input vec_t v);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", W'(lat), W'(WORDS));
    check("sum", sum, v.sum);
    check("c_out", W'(c_out), W'(v.c));
    check("overflow", W'(overflow), W'(v.ovf));
    check("zero", W'(zero), W'(v.z));
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_take", W'({in_ready, out_valid, busy}), W'(3'b100));
  endtask

  initial begin
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_flags", W'({in_ready, out_valid, busy, c_out, overflow, zero}), W'(6'b100000));
    check("reset_sum", sum, '0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_result(vecs[i]);
      release_result();
    end

    // Stall in DONE while new operands are offered: nothing may be accepted.
    start_op(vecs[6].a, vecs[6].b, vecs[6].sub);
    wait_result(vecs[6]);
    a = 32'hDEADBEEF; b = 32'h11111111; sub = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_sum", sum, vecs[6].sum);
      check("hold_flags", W'({in_ready, out_valid, c_out, overflow, zero}), W'(5'b01000));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("no_reaccept", W'({in_ready, out_valid, busy}), W'(3'b100));
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset on the second RUN edge discards the partial result.
    start_op(vecs[1].a, vecs[1].b, vecs[1].sub);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_flags", W'({in_ready, out_valid, busy, c_out, overflow, zero}), W'(6'b100000));
    check("midrun_rst_sum", sum, '0);
    start_op(vecs[5].a, vecs[5].b, vecs[5].sub);
    wait_result(vecs[5]);

    // Reset while in DONE, even with out_ready high, wins over the handshake.
    out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    check("done_rst_flags", W'({in_ready, out_valid, busy, c_out, overflow}), W'(5'b10000));
    check("done_rst_sum", sum, '0);
    start_op(vecs[3].a, vecs[3].b, vecs[3].sub);
    wait_result(vecs[3]);
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
